// File: rtl/mux_nx1_arb.sv
// mux_nx1_arb: N-to-1 fixed/round-robin arbitrated mux into a one-entry output register.
// Define MUX_NX1_ARB_PARITY_EN to add the registered even-parity output out_par.
module mux_nx1_arb #(
    parameter int WIDTH = 4,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_NX1_ARB_PARITY_EN
    ,output logic              out_par
`endif
);
    logic [SELW-1:0]  ptr_q, ptr_d, out_sel_q, out_sel_d, g, idx;
    logic [WIDTH-1:0] out_q, out_d, dsel;
    logic             out_valid_q, out_valid_d, gnt, load;

    always_comb begin
        g = sel;
        idx = '0;
        gnt = 1'b0;
        if (mode) begin
            // Descending scan so the nearest valid channel after ptr wins.
            for (int k = N; k >= 1; k--) begin
                idx = SELW'((int'(ptr_q) + k) % N);
                if (in_valid[idx]) begin
                    g = idx;
                    gnt = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++)
                if (sel == SELW'(i)) gnt = in_valid[i];
        end
        dsel = '0;
        for (int i = 0; i < N; i++)
            if (g == SELW'(i)) dsel = in_data[i*WIDTH +: WIDTH];
        load = gnt && (!out_valid_q || out_ready);
        in_ready = '0;
        if (load && rst_n) in_ready[g] = 1'b1;
        out_d       = load ? dsel : out_q;
        out_sel_d   = load ? g : out_sel_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        ptr_d       = (load && mode) ? g : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

`ifdef MUX_NX1_ARB_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_par_q <= 1'b0;
        else        out_par_q <= ^out_d;
    end

    assign out_par = out_par_q;
`endif
endmodule

// File: tb/tb_mux_nx1_arb.sv
// tb_mux_nx1_arb: directed plus randomised stimulus checked against a behavioural arbiter model.
module tb_mux_nx1_arb;
    localparam int W = 4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic        mode, out_ready, out_valid;
    logic [1:0]  sel, out_sel;
    logic [3:0]  out;
`ifdef MUX_NX1_ARB_PARITY_EN
    logic        out_par;
`endif
    int checks = 0;
    int errors = 0;

    mux_nx1_arb #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out(out), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_NX1_ARB_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    // Model: which channel wins this cycle, -1 when nobody does.
    function automatic int grant(logic md, int s, logic [3:0] v, int p);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    logic       m_v;
    logic [3:0] m_out;
    int         m_sel, m_ptr, m_g;
    logic [3:0] m_ready;

    always_comb m_g = grant(mode, int'(sel), in_valid, m_ptr);
    always_comb m_ready = (rst_n && m_g >= 0 && (!m_v || out_ready)) ? 4'(1 << m_g) : 4'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            m_out <= '0;
            m_sel <= 0;
            m_ptr <= N - 1;
        end else if (m_g >= 0 && (!m_v || out_ready)) begin
            m_v <= 1'b1;
            m_out <= in_data[m_g*W +: W];
            m_sel <= m_g;
            if (mode) m_ptr <= m_g;
        end else if (out_ready) begin
            m_v <= 1'b0;
        end
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model in_ready", 32'(in_ready), 32'(m_ready));
        chk("model out_valid", 32'(out_valid), 32'(m_v));
        if (m_v) begin
            chk("model out", 32'(out), 32'(m_out));
            chk("model out_sel", 32'(out_sel), m_sel);
        end
`ifdef MUX_NX1_ARB_PARITY_EN
        chk("model out_par", 32'(out_par), 32'(^m_out));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_data = 16'hDCBA;
        in_valid = 4'hF;
        mode = 1'b1;
        sel = 2'd0;
        out_ready = 1'b1;
        #12;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out", 32'(out), 0);
        chk("reset out_sel", 32'(out_sel), 0);
        chk("reset in_ready", 32'(in_ready), 0);
        mode = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cyc();
            chk("fixed out", 32'(out), 32'(4'hA + s));
            chk("fixed out_sel", 32'(out_sel), s);
        end
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr out_sel", 32'(out_sel), i % 4);
            chk("rr out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp out_sel", 32'(out_sel), 1);
            chk("bp out", 32'(out), 32'hB);
            chk("bp in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1 chk("bp release in_ready", 32'(in_ready), 32'b0100);
        cyc();
        chk("bp release out_sel", 32'(out_sel), 2);
        in_valid = 4'b0010;
        cyc();
        chk("sparse setup out_sel", 32'(out_sel), 1);
        in_valid = 4'b1001;
        cyc();
        chk("sparse first", 32'(out_sel), 3);
        cyc();
        chk("sparse second", 32'(out_sel), 0);
        mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'b1011;
        #1 chk("fixed idle in_ready", 32'(in_ready), 0);
        cyc();
        chk("fixed idle out_valid", 32'(out_valid), 0);
        mode = 1'b1;
        in_valid = 4'hF;
        cyc();
        chk("ptr kept out_sel", 32'(out_sel), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async in_ready", 32'(in_ready), 0);
        chk("async out", 32'(out), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk("post reset out_sel", 32'(out_sel), 0);
        chk("post reset out_valid", 32'(out_valid), 1);
`ifdef MUX_NX1_ARB_PARITY_EN
        mode = 1'b0;
        in_data = 16'hDC57;
        sel = 2'd0;
        cyc();
        chk("parity 0x7", 32'(out_par), 1);
        sel = 2'd1;
        cyc();
        chk("parity 0x5", 32'(out_par), 0);
`endif
        repeat (300) begin
            in_data = 16'($urandom);
            in_valid = 4'($urandom);
            mode = 1'($urandom);
            sel = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_nx1_arb.md
MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per channel (1..64).
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL have localparam SELW = $clog2(N), the width of the select and grant fields.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion and active-low, fixed for this block.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel accept, combinational.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SELW  channel index used in fixed mode.
REQ-011 SHALL have port out  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_sel  output  SELW  registered index of the channel that supplied out.
REQ-013 SHALL have port out_valid  output  1  out/out_sel hold an unconsumed word.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL implement a one-entry output register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL treat the register as loadable in a cycle when out_valid=0 or out_ready=1.
REQ-017 SHALL, in fixed mode, make channel sel the candidate; a grant occurs only if sel<N and in_valid[sel]=1.
REQ-018 SHALL, in round-robin mode, grant the first channel with in_valid=1, searching from index ptr+1 upward modulo N.
REQ-019 SHALL assert in_ready[g] only for the granted channel g, and only in a loadable cycle; all other in_ready bits SHALL be 0.
REQ-020 SHALL, on a transfer (in_valid[g] && in_ready[g]), capture in_data[g] into out and g into out_sel, and set out_valid=1 at the next edge: 1-cycle latency.
REQ-021 SHALL, when out_valid && out_ready and no grant occurs, go to EMPTY (out_valid=0) at the next edge.
REQ-022 SHALL, when out_ready and a grant coincide, replace the word and keep out_valid=1, sustaining 1 word per cycle.
REQ-023 SHALL hold out and out_sel stable while out_valid=1 && out_ready=0.
REQ-024 SHALL update ptr to g on every round-robin transfer; ptr SHALL be unchanged by fixed-mode transfers and by mode changes.
REQ-025 SHALL take the value of mode and sel from the current cycle only; no pipeline of control.
REQ-026 SHALL produce no grant when sel>=N (non-power-of-2 N) in fixed mode.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out=0, out_sel=0, ptr=N-1, and in_ready=0 regardless of clk.
REQ-028 SHALL discard a pending word on reset mid-operation; the first grant after release SHALL follow REQ-017/018 with ptr=N-1, so channel 0 has round-robin priority.

Configuration
REQ-029 SHALL, with macro MUX_NX1_ARB_PARITY_EN defined, add port out_par  output  1, registered with out and equal to the even parity (XOR) of out, reset to 0.
REQ-030 SHALL, without MUX_NX1_ARB_PARITY_EN, omit out_par entirely, with otherwise identical behaviour.

Verification
REQ-031 SHALL cover fixed mode: N=4, WIDTH=4, in_data channels = {0xD,0xC,0xB,0xA} (ch3..ch0), all valid, out_ready=1, sel stepped 0,1,2,3 each cycle -> out 0xA,0xB,0xC,0xD with out_sel 0..3, one cycle after each sel.
REQ-032 SHALL cover round-robin with all 4 channels valid and out_ready=1 continuously -> out_sel sequence 0,1,2,3,0,1, with out_valid held at 1 every cycle.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles while FULL -> out/out_sel unchanged and in_ready=0000; when out_ready returns to 1, the next word is loaded in that same cycle.
REQ-034 SHALL cover sparse round-robin: with ptr=1 and only ch0 and ch3 valid -> grant ch3 first, then ch0.
REQ-035 SHALL cover reset mid-operation: rst_n dropped asynchronously while out_valid=1 -> out_valid=0 immediately, then after release with all valid -> first out_sel=0.
REQ-036 SHALL cover parity (macro defined): out=0x7 -> out_par=1; out=0x5 -> out_par=0.
